// File: rtl/sm_keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot column strobes, synchronized row sampling,
// full-frame debounce and a valid/ack press-event channel with sticky overflow.
module sm_keypad_scanner #(
  parameter int unsigned SCAN_DIV = 256,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] colOut,
  input  logic [3:0] rowIn,
  output logic       keyValid,
  output logic [3:0] keyCode,
  input  logic       keyAck,
  output logic       keyPressed,
  output logic       overflow
);

  localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 32'd1);
  localparam logic [3:0]  DEB_MAX   = 4'(DEBOUNCE);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  // Frame bits are stored column-major (col*4+row); events use row*4+col.
  function automatic logic [15:0] to_key_order(input logic [15:0] frame);
    logic [15:0] keys;
    keys = 16'h0000;
    for (int k = 0; k < 16; k++) keys[k] = frame[4 * (k % 4) + (k / 4)];
    return keys;
  endfunction

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 15; k >= 0; k--) if (v[k]) idx = 4'(k);
    return idx;
  endfunction

  logic [3:0]  row_meta_r, row_sync_r;
  logic [15:0] slot_cnt_r;
  logic [1:0]  col_idx_r;
  logic [15:0] frame_acc_r, frame_prev_r;
  logic [3:0]  stable_cnt_r;
  logic [15:0] debounced_r, prev_debounced_r;
  state_t      state_r;

  logic        slot_tc_s, frame_end_s, multi_s;
  logic [15:0] frame_next_s, new_press_s;
  logic [3:0]  stable_next_s;

  // Merge the synchronized rows into the current column of the frame.
  always_comb begin
    frame_next_s = frame_acc_r;
    case (col_idx_r)
      2'd0:    frame_next_s[3:0]   = row_sync_r;
      2'd1:    frame_next_s[7:4]   = row_sync_r;
      2'd2:    frame_next_s[11:8]  = row_sync_r;
      2'd3:    frame_next_s[15:12] = row_sync_r;
      default: frame_next_s        = frame_acc_r;
    endcase
  end

  // Slot/frame timing and next stable count.
  always_comb begin
    slot_tc_s   = (slot_cnt_r == SLOT_LAST);
    frame_end_s = slot_tc_s && (col_idx_r == 2'd3);
    if (frame_next_s != frame_prev_r) begin
      stable_next_s = 4'd0;
    end else if (stable_cnt_r >= DEB_MAX) begin
      stable_next_s = DEB_MAX;
    end else begin
      stable_next_s = stable_cnt_r + 4'd1;
    end
  end

  // Rising edges of the debounced matrix, in key-index order.
  always_comb begin
    new_press_s = to_key_order(debounced_r & ~prev_debounced_r);
    multi_s     = ((new_press_s & (new_press_s - 16'd1)) != 16'd0);
  end

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'd0;
      row_sync_r <= 4'd0;
    end else begin
      row_meta_r <= rowIn;
      row_sync_r <= row_meta_r;
    end
  end

  // Column slot counter, strobe rotation and frame accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r  <= 16'd0;
      col_idx_r   <= 2'd0;
      colOut      <= 4'b0001;
      frame_acc_r <= 16'd0;
    end else if (slot_tc_s) begin
      slot_cnt_r  <= 16'd0;
      col_idx_r   <= col_idx_r + 2'd1;
      colOut      <= {colOut[2:0], colOut[3]};
      frame_acc_r <= frame_next_s;
    end else begin
      slot_cnt_r  <= slot_cnt_r + 16'd1;
    end
  end

  // Frame-to-frame debounce of the whole matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_prev_r     <= 16'd0;
      stable_cnt_r     <= 4'd0;
      debounced_r      <= 16'd0;
      prev_debounced_r <= 16'd0;
      keyPressed       <= 1'b0;
    end else begin
      prev_debounced_r <= debounced_r;
      keyPressed       <= |debounced_r;
      if (frame_end_s) begin
        frame_prev_r <= frame_next_s;
        stable_cnt_r <= stable_next_s;
        if (stable_next_s == DEB_MAX) debounced_r <= frame_next_s;
      end
    end
  end

  // Event FSM: one pending event, drops flagged on the sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      keyValid <= 1'b0;
      keyCode  <= 4'd0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (new_press_s != 16'd0) begin
            state_r  <= ST_PEND;
            keyValid <= 1'b1;
            keyCode  <= lowest_index(new_press_s);
            if (multi_s) overflow <= 1'b1;
          end
        end
        ST_PEND: begin
          if (keyAck) begin
            if (new_press_s != 16'd0) begin
              keyCode <= lowest_index(new_press_s);
              if (multi_s) overflow <= 1'b1;
            end else begin
              state_r  <= ST_IDLE;
              keyValid <= 1'b0;
            end
          end else if (new_press_s != 16'd0) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          keyValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_keypad_scanner.sv
// Directed bench for sm_keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames);
// a small keypad model drives rowIn from the held-key set and colOut.
module tb_sm_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] colOut;
  logic [3:0] rowIn;
  logic       keyValid;
  logic [3:0] keyCode;
  logic       keyAck;
  logic       keyPressed;
  logic       overflow;

  logic [15:0] keys;
  int checks = 0;
  int passes = 0;

  sm_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst_n(rst_n), .colOut(colOut), .rowIn(rowIn),
    .keyValid(keyValid), .keyCode(keyCode), .keyAck(keyAck),
    .keyPressed(keyPressed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Key r*4+c pulls row r high while column c is strobed.
  always_comb begin
    rowIn = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r * 4 + c] && colOut[c]) rowIn[r] = 1'b1;
  end

  task automatic wait_frame_start(output bit ok);
    logic [3:0] prev;
    prev = colOut;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (prev == 4'b1000 && colOut == 4'b0001) begin
        ok = 1'b1;
        break;
      end
      prev = colOut;
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (keyValid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; keyAck = 1'b0; keys = 16'h0000;
    #12;
    checks++; if (colOut !== 4'b0001) $display("FAIL reset_col got=%b exp=0001", colOut); else passes++;
    checks++; if (keyValid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", keyValid); else passes++;
    checks++; if (keyCode !== 4'd0) $display("FAIL reset_code got=%0d exp=0", keyCode); else passes++;
    checks++; if (keyPressed !== 1'b0) $display("FAIL reset_pressed got=%b exp=0", keyPressed); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow); else passes++;
  endtask

  task automatic test_scan;
    logic [3:0] exp_col;
    logic [3:0] one;
    one = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      if (n > 0) @(negedge clk);
      exp_col = one << ((n / 4) % 4);
      checks++; if (colOut !== exp_col) $display("FAIL scan_col cyc=%0d got=%b exp=%b", n, colOut, exp_col); else passes++;
      checks++; if (keyValid !== 1'b0) $display("FAIL scan_valid cyc=%0d got=%b exp=0", n, keyValid); else passes++;
      checks++; if (keyPressed !== 1'b0) $display("FAIL scan_pressed cyc=%0d got=%b exp=0", n, keyPressed); else passes++;
    end
  endtask

  task automatic test_single_press;
    bit ok;
    int n;
    wait_frame_start(ok);
    checks++; if (!ok) $display("FAIL single_sync got=timeout exp=frame start"); else passes++;
    keys[6] = 1'b1;
    wait_valid(100, n);
    checks++; if (n != 49) $display("FAIL single_latency got=%0d exp=49", n); else passes++;
    checks++; if (keyCode !== 4'd6) $display("FAIL single_code got=%0d exp=6", keyCode); else passes++;
    checks++; if (keyPressed !== 1'b1) $display("FAIL single_pressed got=%b exp=1", keyPressed); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL single_ovf got=%b exp=0", overflow); else passes++;
    @(negedge clk); keyAck = 1'b1;
    @(negedge clk);
    checks++; if (keyValid !== 1'b0) $display("FAIL single_ack got=%b exp=0", keyValid); else passes++;
    keyAck = 1'b0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      checks++; if (keyValid !== 1'b0) $display("FAIL single_held cyc=%0d got=%b exp=0", i, keyValid); else passes++;
    end
    keys = 16'h0000;
    repeat (64) @(negedge clk);
    checks++; if (keyPressed !== 1'b0) $display("FAIL single_release got=%b exp=0", keyPressed); else passes++;
    checks++; if (keyValid !== 1'b0) $display("FAIL single_rel_valid got=%b exp=0", keyValid); else passes++;
  endtask

  task automatic test_glitch;
    bit ok;
    wait_frame_start(ok);
    checks++; if (!ok) $display("FAIL glitch_sync got=timeout exp=frame start"); else passes++;
    keys[8] = 1'b1;
    repeat (16) @(negedge clk);
    keys = 16'h0000;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      checks++; if (keyValid !== 1'b0) $display("FAIL glitch_valid cyc=%0d got=%b exp=0", i, keyValid); else passes++;
      checks++; if (keyPressed !== 1'b0) $display("FAIL glitch_pressed cyc=%0d got=%b exp=0", i, keyPressed); else passes++;
    end
  endtask

  task automatic test_multi_press;
    bit ok;
    int n;
    wait_frame_start(ok);
    checks++; if (!ok) $display("FAIL multi_sync got=timeout exp=frame start"); else passes++;
    keys = 16'h0220;
    wait_valid(100, n);
    checks++; if (n != 49) $display("FAIL multi_latency got=%0d exp=49", n); else passes++;
    checks++; if (keyCode !== 4'd5) $display("FAIL multi_code got=%0d exp=5", keyCode); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL multi_ovf got=%b exp=1", overflow); else passes++;
    @(negedge clk); keyAck = 1'b1;
    @(negedge clk);
    checks++; if (keyValid !== 1'b0) $display("FAIL multi_ack got=%b exp=0", keyValid); else passes++;
    keyAck = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++; if (keyValid !== 1'b0) $display("FAIL multi_no9 cyc=%0d got=%b exp=0", i, keyValid); else passes++;
    end
    keys = 16'h0000;
    repeat (64) @(negedge clk);
  endtask

  task automatic reset_pulse;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) $display("FAIL pulse_ovf got=%b exp=0", overflow); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_drop_and_collide;
    bit ok;
    int n;
    keys[3] = 1'b1;
    wait_valid(100, n);
    checks++; if (n == 0) $display("FAIL drop_first got=timeout exp=event"); else passes++;
    checks++; if (keyCode !== 4'd3) $display("FAIL drop_code3 got=%0d exp=3", keyCode); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL drop_ovf0 got=%b exp=0", overflow); else passes++;
    keys[12] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++; if (keyValid !== 1'b1 || keyCode !== 4'd3)
        $display("FAIL drop_hold cyc=%0d got=%b/%0d exp=1/3", i, keyValid, keyCode); else passes++;
    end
    checks++; if (overflow !== 1'b1) $display("FAIL drop_ovf got=%b exp=1", overflow); else passes++;
    wait_frame_start(ok);
    checks++; if (!ok) $display("FAIL collide_sync got=timeout exp=frame start"); else passes++;
    keys[0] = 1'b1;
    repeat (48) @(posedge clk);
    @(negedge clk);
    checks++; if (keyValid !== 1'b1 || keyCode !== 4'd3)
      $display("FAIL collide_pre got=%b/%0d exp=1/3", keyValid, keyCode); else passes++;
    keyAck = 1'b1;
    @(posedge clk); #1;
    checks++; if (keyValid !== 1'b1) $display("FAIL collide_valid got=%b exp=1", keyValid); else passes++;
    checks++; if (keyCode !== 4'd0) $display("FAIL collide_code got=%0d exp=0", keyCode); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL collide_ovf got=%b exp=1", overflow); else passes++;
    @(negedge clk); keyAck = 1'b0;
    @(negedge clk); keyAck = 1'b1;
    @(negedge clk);
    checks++; if (keyValid !== 1'b0) $display("FAIL collide_ack got=%b exp=0", keyValid); else passes++;
    keyAck = 1'b0;
  endtask

  task automatic test_reset_mid_scan;
    bit ok;
    int n;
    keys = 16'h8000;
    wait_valid(100, n);
    checks++; if (n == 0 || keyCode !== 4'd15) $display("FAIL mid_pre got=%0d/%0d exp=event/15", n, keyCode); else passes++;
    wait_frame_start(ok);
    checks++; if (!ok) $display("FAIL mid_sync got=timeout exp=frame start"); else passes++;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (colOut !== 4'b0001) $display("FAIL mid_col got=%b exp=0001", colOut); else passes++;
    checks++; if (keyValid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", keyValid); else passes++;
    checks++; if (keyCode !== 4'd0) $display("FAIL mid_code got=%0d exp=0", keyCode); else passes++;
    checks++; if (keyPressed !== 1'b0) $display("FAIL mid_pressed got=%b exp=0", keyPressed); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL mid_ovf got=%b exp=0", overflow); else passes++;
    @(negedge clk); rst_n = 1'b1;
    wait_valid(100, n);
    checks++; if (n != 49) $display("FAIL mid_latency got=%0d exp=49", n); else passes++;
    checks++; if (keyCode !== 4'd15) $display("FAIL mid_code15 got=%0d exp=15", keyCode); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL mid_ovf_after got=%b exp=0", overflow); else passes++;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_single_press;
    test_glitch;
    test_multi_press;
    reset_pulse;
    test_drop_and_collide;
    test_reset_mid_scan;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
